// File: rtl/simple_merger.sv
// simple_merger: four-to-one valid/ready stream merger with a single registered output stage.
// Each accepted word is tagged with the 2-bit index of its source port.
// Arbitration is round-robin by default. Defining SIMPLE_MERGER_FIXED_PRIO_EN selects fixed
// priority instead (port 0 highest) and removes the rotating pointer.

module simple_merger #(
    parameter int unsigned DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [DATA_SIZE-1:0] din0,
    input  logic [DATA_SIZE-1:0] din1,
    input  logic [DATA_SIZE-1:0] din2,
    input  logic [DATA_SIZE-1:0] din3,
    input  logic [3:0]           din_valid,
    output logic [3:0]           din_ready,
    output logic [DATA_SIZE-1:0] dout,
    output logic [1:0]           dout_addr,
    output logic                 dout_en,
    input  logic                 dout_ready
);

    logic [DATA_SIZE-1:0] r_dout;
    logic [1:0]           r_dout_addr;
    logic                 r_dout_en;

    logic [1:0]           w_base;       // port scanned first
    logic [3:0]           w_rot;        // din_valid rotated so bit 0 is port w_base
    logic [1:0]           w_off;        // offset of the winner from w_base
    logic                 w_grant_vld;
    logic [1:0]           w_grant_idx;
    logic                 w_load_ok;
    logic                 w_hs;
    logic [DATA_SIZE-1:0] w_grant_data;

`ifdef SIMPLE_MERGER_FIXED_PRIO_EN
    assign w_base = 2'd0;
`else
    logic [1:0] r_ptr;

    assign w_base = r_ptr;

    // Round-robin pointer: moves past the winner on every handshake only
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ptr <= 2'd0;
        end else if (w_hs) begin
            r_ptr <= w_grant_idx + 2'd1;
        end
    end
`endif

    // Rotate the valid vector and pick the first set bit relative to the base port
    always_comb begin
        w_rot       = 4'({din_valid, din_valid} >> w_base);
        w_grant_vld = 1'b1;
        w_off       = 2'd0;
        if (w_rot[0]) begin
            w_off = 2'd0;
        end else if (w_rot[1]) begin
            w_off = 2'd1;
        end else if (w_rot[2]) begin
            w_off = 2'd2;
        end else if (w_rot[3]) begin
            w_off = 2'd3;
        end else begin
            w_grant_vld = 1'b0;
        end
        w_grant_idx = w_base + w_off;
    end

    // Handshake qualification and one-hot ready; gated by resetn so nothing is accepted in reset
    always_comb begin
        w_load_ok = ~r_dout_en | dout_ready;
        w_hs      = resetn & w_load_ok & w_grant_vld;
        din_ready = w_hs ? (4'b0001 << w_grant_idx) : 4'b0000;
    end

    // Select the winning data word
    always_comb begin
        w_grant_data = din0;
        unique case (w_grant_idx)
            2'd0: w_grant_data = din0;
            2'd1: w_grant_data = din1;
            2'd2: w_grant_data = din2;
            2'd3: w_grant_data = din3;
            default: w_grant_data = din0;
        endcase
    end

    // Output entry: load on handshake, clear on drain without reload, otherwise hold
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dout      <= '0;
            r_dout_addr <= 2'd0;
            r_dout_en   <= 1'b0;
        end else if (w_hs) begin
            r_dout      <= w_grant_data;
            r_dout_addr <= w_grant_idx;
            r_dout_en   <= 1'b1;
        end else if (r_dout_en && dout_ready) begin
            r_dout      <= '0;
            r_dout_addr <= 2'd0;
            r_dout_en   <= 1'b0;
        end
    end

    assign dout      = r_dout;
    assign dout_addr = r_dout_addr;
    assign dout_en   = r_dout_en;

endmodule

// File: tb/tb_simple_merger.sv
// Testbench for simple_merger: directed table, hand-written corner sequences and a randomized
// phase checked against a behavioural model of the merge/arbitration rules.

module tb_simple_merger;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] dins [4];
    logic [3:0]  din_valid;
    logic [3:0]  din_ready;
    logic [31:0] dout;
    logic [1:0]  dout_addr;
    logic        dout_en;
    logic        dout_ready;

    int n_checks = 0;
    int n_fail   = 0;

    simple_merger #(.DATA_SIZE(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .din0       (dins[0]),
        .din1       (dins[1]),
        .din2       (dins[2]),
        .din3       (dins[3]),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_addr  (dout_addr),
        .dout_en    (dout_en),
        .dout_ready (dout_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle, entered at posedge+1: drive, check ready mid-cycle, check outputs after the edge
    task automatic cyc(input logic [3:0] v, input logic rdy, input logic [3:0] e_rdy,
                       input logic [31:0] e_dout, input logic [1:0] e_addr, input logic e_en,
                       input string name);
        din_valid  = v;
        dout_ready = rdy;
        #2;
        chk({name, "_ready"}, 32'(din_ready), 32'(e_rdy));
        @(posedge clk);
        #1;
        chk({name, "_dout"}, dout, e_dout);
        chk({name, "_addr"}, 32'(dout_addr), 32'(e_addr));
        chk({name, "_en"}, 32'(dout_en), 32'(e_en));
    endtask

    // Behavioural reference model
    int          m_ptr;
    logic        m_en;
    logic [31:0] m_dout;
    logic [1:0]  m_addr;

    function automatic int m_grant(input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
`ifdef SIMPLE_MERGER_FIXED_PRIO_EN
            int p = k;
`else
            int p = (m_ptr + k) % 4;
`endif
            if (v[p]) return p;
        end
        return -1;
    endfunction

    typedef struct {
        logic [3:0]  v;
        logic        rdy;
        logic [31:0] d2;
        logic [3:0]  e_rdy;
        logic [31:0] e_dout;
        logic [1:0]  e_addr;
        logic        e_en;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // Directed vectors; din0..3 are 10..13 except din2 taken from the row
`ifdef SIMPLE_MERGER_FIXED_PRIO_EN
        for (int i = 0; i < 6; i++)
            tbl.push_back('{4'hF, 1'b1, 32'h12, 4'b0001, 32'h10, 2'd0, 1'b1});
        tbl.push_back('{4'b0100, 1'b1, 32'hA5A5_0002, 4'b0100, 32'hA5A5_0002, 2'd2, 1'b1});
        tbl.push_back('{4'hF, 1'b1, 32'h12, 4'b0001, 32'h10, 2'd0, 1'b1});
        tbl.push_back('{4'hE, 1'b1, 32'h12, 4'b0010, 32'h11, 2'd1, 1'b1});
`else
        tbl.push_back('{4'hF, 1'b1, 32'h12, 4'b0001, 32'h10, 2'd0, 1'b1});
        tbl.push_back('{4'hF, 1'b1, 32'h12, 4'b0010, 32'h11, 2'd1, 1'b1});
        tbl.push_back('{4'hF, 1'b1, 32'h12, 4'b0100, 32'h12, 2'd2, 1'b1});
        tbl.push_back('{4'hF, 1'b1, 32'h12, 4'b1000, 32'h13, 2'd3, 1'b1});
        tbl.push_back('{4'hF, 1'b1, 32'h12, 4'b0001, 32'h10, 2'd0, 1'b1});
        tbl.push_back('{4'hF, 1'b1, 32'h12, 4'b0010, 32'h11, 2'd1, 1'b1});
        tbl.push_back('{4'b0100, 1'b1, 32'hA5A5_0002, 4'b0100, 32'hA5A5_0002, 2'd2, 1'b1});
`endif
        tbl.push_back('{4'b0000, 1'b1, 32'h12, 4'b0000, 32'h0, 2'd0, 1'b0});

        // Reset held with all sources valid
        resetn     = 1'b0;
        din_valid  = 4'hF;
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) dins[i] = 32'h10 + 32'(i);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_dout", dout, 32'h0);
            chk("rst_addr", 32'(dout_addr), 32'h0);
            chk("rst_en", 32'(dout_en), 32'h0);
            chk("rst_ready", 32'(din_ready), 32'h0);
        end
        resetn = 1'b1;

        foreach (tbl[i]) begin
            dins[2] = tbl[i].d2;
            cyc(tbl[i].v, tbl[i].rdy, tbl[i].e_rdy, tbl[i].e_dout, tbl[i].e_addr, tbl[i].e_en,
                $sformatf("tbl%0d", i));
        end
        dins[2] = 32'h12;

        // Backpressure: hold DEADBEEF from port 1, then drain and reload port 3 in one edge
        dins[1] = 32'hDEAD_BEEF;
        cyc(4'b0010, 1'b1, 4'b0010, 32'hDEAD_BEEF, 2'd1, 1'b1, "bp_load");
        for (int i = 0; i < 3; i++)
            cyc(4'b1000, 1'b0, 4'b0000, 32'hDEAD_BEEF, 2'd1, 1'b1, $sformatf("bp_hold%0d", i));
        cyc(4'b1000, 1'b1, 4'b1000, 32'h13, 2'd3, 1'b1, "bp_reload");

        // Reset mid-stream with an entry pending
        cyc(4'b0010, 1'b1, 4'b0010, 32'hDEAD_BEEF, 2'd1, 1'b1, "mr_load");
        #2;
        resetn = 1'b0;
        #1;
        chk("mr_en", 32'(dout_en), 32'h0);
        chk("mr_dout", dout, 32'h0);
        chk("mr_ready", 32'(din_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("mr_hold_en", 32'(dout_en), 32'h0);
        resetn  = 1'b1;
        dins[1] = 32'h11;
        cyc(4'hF, 1'b1, 4'b0001, 32'h10, 2'd0, 1'b1, "mr_first");

        // Fresh reset, then randomized traffic against the model
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        m_ptr  = 0;
        m_en   = 1'b0;
        m_dout = 32'h0;
        m_addr = 2'd0;
        for (int i = 0; i < 400; i++) begin
            int          g;
            logic        lok;
            logic [3:0]  e_rdy;
            for (int j = 0; j < 4; j++) dins[j] = $urandom;
            din_valid  = 4'($urandom_range(0, 15));
            dout_ready = ($urandom_range(0, 3) != 0);
            #2;
            g     = m_grant(din_valid);
            lok   = !m_en || dout_ready;
            e_rdy = (lok && g >= 0) ? (4'b0001 << g) : 4'b0000;
            chk("rnd_ready", 32'(din_ready), 32'(e_rdy));
            @(posedge clk);
            if (lok && g >= 0) begin
                m_dout = dins[g];
                m_addr = 2'(g);
                m_en   = 1'b1;
                m_ptr  = (g + 1) % 4;
            end else if (m_en && dout_ready) begin
                m_dout = 32'h0;
                m_addr = 2'd0;
                m_en   = 1'b0;
            end
            #1;
            chk("rnd_dout", dout, m_dout);
            chk("rnd_addr", 32'(dout_addr), 32'(m_addr));
            chk("rnd_en", 32'(dout_en), 32'(m_en));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/simple_merger.md
# simple_merger

Four-to-one stream merger, the collecting counterpart of the address-steered 1-to-4 router. It accepts words from four source ports over valid/ready handshakes and arbitrates between them round-robin. The winning word goes into a single registered output stage, tagged with the 2-bit index of the source port, so a downstream router can steer it back out by that address. It sits where four producer lanes share one bus ahead of an address-steered router.

## Interface
- DATA_SIZE, 32, width of every data word
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- din0, din1, din2, din3  input  DATA_SIZE each  source data words
- din_valid  input  4  bit i set: dinI holds a valid word
- din_ready  output  4  bit i set: dinI is accepted this cycle (handshake when din_valid[i] & din_ready[i])
- dout  output  DATA_SIZE  merged data word (registered)
- dout_addr  output  2  index of the source port of dout (registered)
- dout_en  output  1  output valid (registered)
- dout_ready  input  1  downstream accepts dout this cycle

## Operation
- State: one output entry (dout, dout_addr, dout_en) and a 2-bit round-robin pointer ptr.
- load_ok = !dout_en | dout_ready. The entry is empty, or it drains this cycle.
- Grant: scan ports ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first port with din_valid set wins.
- din_ready is one-hot on the granted port when load_ok=1. It is all-zero when load_ok=0 or no port is valid.
- din_ready is combinational from din_valid, ptr, dout_en and dout_ready. Sources must not make din_valid depend on din_ready.
- On a handshake on port i:
  - dout <= dinI, dout_addr <= i, dout_en <= 1.
  - ptr <= (i+1) mod 4. Wrap-around from port 3 goes to port 0.
- On drain without reload (dout_en & dout_ready, no valid port): dout_en <= 0, dout <= 0, dout_addr <= 0.
- While dout_en=1 and dout_ready=0, the entry is held stable:
  - dout, dout_addr and dout_en do not change.
  - din_ready = 0.
- Drain and reload in the same cycle are legal. This gives full throughput, one word per cycle, while dout_ready stays high.
- ptr changes only on a handshake. With no handshake it holds its value.
- dout and dout_addr are all-zero whenever dout_en=0.

## Timing
- Reset (resetn low, asynchronous): dout=0, dout_addr=0, dout_en=0, ptr=0.
- din_ready is 0 during reset, since it is gated by resetn.
- Reset asserted mid-operation discards any pending entry immediately. No handshake completes while resetn is low.
- Deassertion of resetn is synchronised externally. The first accept can happen in the first clk edge with resetn high.
- Latency: a word accepted at edge N appears on dout with dout_en=1 immediately after edge N. It is visible during cycle N+1.
- Throughput: 1 word/cycle.
- Fairness: with all four ports continuously valid and dout_ready=1, each port is granted exactly once in every 4 consecutive grants.
- Backpressure response is 0 cycles: din_ready drops in the same cycle that dout_ready=0 meets dout_en=1.

## Configuration
- SIMPLE_MERGER_FIXED_PRIO_EN
  - Defined: fixed priority, port 0 highest and port 3 lowest. ptr is removed and its state is not built.
  - Undefined (default): round-robin as described above.
- All handshake, latency and reset behaviour is identical in both builds.

## Test plan
- Reset: hold resetn=0 with din_valid=4'hF.
  - Required: dout=0, dout_addr=0, dout_en=0, din_ready=0 throughout.
  - Release reset: first grant goes to port 0.
- Single source: din2=32'hA5A5_0002, din_valid=4'b0100, dout_ready=1 for one cycle.
  - Required: din_ready=4'b0100 that cycle.
  - Next cycle: dout=32'hA5A5_0002, dout_addr=2, dout_en=1.
  - Following cycle: dout_en=0, dout=0.
- Round-robin wrap: all din_valid=1 with din0..3 = 32'h10..32'h13, dout_ready=1 for 6 cycles.
  - Required: dout_addr sequence 0,1,2,3,0,1 with matching dout.
- Backpressure: entry holding 32'hDEAD_BEEF, addr 1; dout_ready=0 for 3 cycles with din_valid=4'b1000.
  - Required: din_ready=0 and outputs stable for all 3 cycles.
  - Then dout_ready=1: drain and reload in the same edge, giving next dout_addr=3.
- Fixed priority build (SIMPLE_MERGER_FIXED_PRIO_EN defined): all ports valid, dout_ready=1 for 4 cycles.
  - Required: dout_addr=0 every cycle.
  - Then drop din_valid[0]: dout_addr=1.
- Reset mid-stream: pull resetn low asynchronously between edges while dout_en=1 and ptr=2.
  - Required: dout_en=0 and dout=0 immediately.
  - After release, with all ports valid, the first grant is port 0.
